// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared encodings for the intersection phase scheduler: lamp values, controller
// states and the per-approach lamp decode used by the sig_control logic.
package intersection_phase_scheduler_pkg;

  typedef enum logic [1:0] {
    SIG_RED    = 2'd0,
    SIG_YELLOW = 2'd1,
    SIG_GREEN  = 2'd2
  } sig_t;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  // Only the approach that owns the phase ever shows a non-RED lamp.
  function automatic sig_t approach_sig(input state_t st, input logic [1:0] owner,
                                        input logic [1:0] idx);
    sig_t s;
    s = SIG_RED;
    if (owner == idx) begin
      case (st)
        ST_GREEN:  s = SIG_GREEN;
        ST_YELLOW: s = SIG_YELLOW;
        default:   s = SIG_RED;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_rr_pick4.sv
// Combinational round-robin picker: first asserted request after 'last',
// wrapping around and checking 'last' itself at lowest priority.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    winner = 2'd0;
    idx    = 2'd0;
    // Walk from lowest to highest priority so the nearest requester wins.
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-approach traffic phase controller: ALLRED -> GREEN -> YELLOW cycling with
// min/max green timing and round-robin hand-over; all outputs come from flops.
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int Y_TIME    = 3,
  parameter int R_TIME    = 2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] req,
  output logic [7:0] sig,
  output logic [1:0] phase,
  output logic       phase_start
);

  localparam int TMAX_A = (MAX_GREEN > Y_TIME) ? MAX_GREEN : Y_TIME;
  localparam int TMAX   = (TMAX_A > R_TIME) ? TMAX_A : R_TIME;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] R_LAST   = TW'(R_TIME - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [1:0]    phase_reg, phase_next;
  logic [7:0]    sig_reg, sig_next;
  logic          phase_start_reg, phase_start_next;

  logic [1:0] rr_winner;
  logic       rr_any;
  logic [3:0] contenders;
  logic       owner_req;

  rr_pick4 u_rr_pick4 (
    .req    (req),
    .last   (phase_reg),
    .winner (rr_winner),
    .any    (rr_any)
  );

  assign contenders = req & ~(4'b0001 << phase_reg);
  assign owner_req  = req[phase_reg];

  // State register; outputs are registered from the next-state decode so they
  // always describe the state the block is currently in.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg       <= ST_ALLRED;
      timer_reg       <= '0;
      phase_reg       <= 2'd0;
      sig_reg         <= 8'h00;
      phase_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      phase_reg       <= phase_next;
      sig_reg         <= sig_next;
      phase_start_reg <= phase_start_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    phase_next = phase_reg;
    case (state_reg)
      ST_ALLRED: begin
        if (timer_reg == R_LAST) begin
          state_next = ST_GREEN;
          timer_next = '0;
          phase_next = rr_any ? rr_winner : 2'd0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_GREEN: begin
        // Yield early only when the owner has gone quiet; at max green yield anyway.
        if ((|contenders) &&
            (((timer_reg >= MIN_LAST) && !owner_req) || (timer_reg == MAX_LAST))) begin
          state_next = ST_YELLOW;
          timer_next = '0;
        end else if (timer_reg != MAX_LAST) begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_YELLOW: begin
        if (timer_reg == Y_LAST) begin
          state_next = ST_ALLRED;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_ALLRED;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin : sig_control
    phase_start_next = (state_next == ST_GREEN) && (timer_next == '0);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
    assign sig_next[2*gi +: 2] = approach_sig(state_next, phase_next, 2'(gi));
  end

  assign sig         = sig_reg;
  assign phase       = phase_reg;
  assign phase_start = phase_start_reg;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed timing scenarios plus random
// request traffic compared every cycle against a cycle-count reference model.
module tb_intersection_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int Y_T   = 3;
  localparam int R_T   = 2;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] req;
  logic [7:0] sig;
  logic [1:0] phase;
  logic       phase_start;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0=all red, 1=green, 2=yellow; cnt = cycles already
  // spent in the mode; owner = approach holding the phase.
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_owner = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .Y_TIME    (Y_T),
    .R_TIME    (R_T)
  ) dut (
    .clock       (clk),
    .clear       (clear),
    .req         (req),
    .sig         (sig),
    .phase       (phase),
    .phase_start (phase_start)
  );

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int nm, nc, no;
    logic [3:0] others;
    nm = m_mode; nc = m_cnt; no = m_owner;
    others = req & ~(4'b0001 << m_owner);
    if (clear) begin
      nm = 0; nc = 0; no = 0;
    end else if (m_mode == 0) begin
      if (m_cnt + 1 >= R_T) begin nm = 1; nc = 0; no = pick(req, m_owner); end
      else nc = m_cnt + 1;
    end else if (m_mode == 1) begin
      if (others != 0 && (m_cnt + 1 >= MAX_G || (m_cnt + 1 >= MIN_G && !req[m_owner]))) begin
        nm = 2; nc = 0;
      end else begin
        nc = (m_cnt + 1 < MAX_G) ? m_cnt + 1 : MAX_G - 1;
      end
    end else begin
      if (m_cnt + 1 >= Y_T) begin nm = 0; nc = 0; end
      else nc = m_cnt + 1;
    end
    m_mode  <= nm;
    m_cnt   <= nc;
    m_owner <= no;
  end

  // Per-cycle scoreboard against the model plus the single-non-RED safety rule.
  always @(negedge clk) begin : monitor
    logic [7:0] exp_sig;
    int nonred;
    exp_sig = 8'h00;
    if (m_mode == 1) exp_sig[2*m_owner +: 2] = 2'd2;
    else if (m_mode == 2) exp_sig[2*m_owner +: 2] = 2'd1;
    checks++;
    if (sig !== exp_sig) begin
      failures++;
      if (failures < 30) $display("FAIL model_sig t=%0t got=%h exp=%h", $time, sig, exp_sig);
    end
    checks++;
    if (phase !== m_owner[1:0]) begin
      failures++;
      if (failures < 30) $display("FAIL model_phase t=%0t got=%0d exp=%0d", $time, phase, m_owner);
    end
    checks++;
    if (phase_start !== (m_mode == 1 && m_cnt == 0)) begin
      failures++;
      if (failures < 30) $display("FAIL model_phase_start t=%0t got=%b exp=%b", $time,
                                  phase_start, (m_mode == 1 && m_cnt == 0));
    end
    nonred = 0;
    for (int i = 0; i < 4; i++) if (sig[2*i +: 2] !== 2'd0) nonred++;
    checks++;
    if (nonred > 1) begin
      failures++;
      if (failures < 30) $display("FAIL one_hot t=%0t sig=%h nonred=%0d", $time, sig, nonred);
    end
  end

  task automatic count_run(input logic [7:0] v, output int n);
    n = 0;
    while (sig === v && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset(input logic [3:0] r);
    req   = r;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_green();
    int n;
    n = 0;
    while (phase_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n, hold;
    clear = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({sig, phase, phase_start} !== 11'b0) begin
        failures++;
        $display("FAIL reset_outputs got sig=%h phase=%0d ps=%b exp 00/0/0", sig, phase, phase_start);
      end
    end
    clear = 1'b0;
    n = 0;
    while (sig !== 8'h02 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== R_T) begin
      failures++;
      $display("FAIL allred_after_reset got=%0d exp=%0d", n, R_T);
    end
    checks++;
    if (phase_start !== 1'b1 || phase !== 2'd0) begin
      failures++;
      $display("FAIL first_green got ps=%b phase=%0d exp 1/0", phase_start, phase);
    end
    hold = 0;
    repeat (25) begin
      @(negedge clk);
      if (sig === 8'h02 && phase_start === 1'b0) hold++;
    end
    checks++;
    if (hold !== 25) begin
      failures++;
      $display("FAIL rest_on_highway got=%0d exp=25", hold);
    end
  endtask

  task automatic test_max_green();
    int n;
    apply_reset(4'b0001);
    wait_green();
    req = 4'b0101;
    count_run(8'h02, n);
    checks++;
    if (n !== MAX_G) begin failures++; $display("FAIL max_green_len got=%0d exp=%0d", n, MAX_G); end
    count_run(8'h01, n);
    checks++;
    if (n !== Y_T) begin failures++; $display("FAIL max_yellow_len got=%0d exp=%0d", n, Y_T); end
    count_run(8'h00, n);
    checks++;
    if (n !== R_T) begin failures++; $display("FAIL max_allred_len got=%0d exp=%0d", n, R_T); end
    checks++;
    if (sig !== 8'h20 || phase !== 2'd2 || phase_start !== 1'b1) begin
      failures++;
      $display("FAIL max_next_phase got sig=%h phase=%0d ps=%b exp 20/2/1", sig, phase, phase_start);
    end
  endtask

  task automatic test_min_green();
    int n;
    apply_reset(4'b0001);
    wait_green();
    req = 4'b0010;
    count_run(8'h02, n);
    checks++;
    if (n !== MIN_G) begin failures++; $display("FAIL min_green_len got=%0d exp=%0d", n, MIN_G); end
    count_run(8'h01, n);
    count_run(8'h00, n);
    checks++;
    if (sig !== 8'h08 || phase !== 2'd1) begin
      failures++;
      $display("FAIL min_next_phase got sig=%h phase=%0d exp 08/1", sig, phase);
    end
  endtask

  task automatic test_wraparound();
    int n;
    apply_reset(4'b1000);
    wait_green();
    checks++;
    if (phase !== 2'd3 || sig !== 8'h80) begin
      failures++;
      $display("FAIL wrap_setup got sig=%h phase=%0d exp 80/3", sig, phase);
    end
    req = 4'b0001;
    count_run(8'h80, n);
    req = 4'b1011;
    count_run(8'h40, n);
    checks++;
    if (n !== Y_T) begin failures++; $display("FAIL wrap_yellow_len got=%0d exp=%0d", n, Y_T); end
    count_run(8'h00, n);
    checks++;
    if (phase !== 2'd0 || sig !== 8'h02) begin
      failures++;
      $display("FAIL wrap_winner got sig=%h phase=%0d exp 02/0", sig, phase);
    end
  endtask

  task automatic test_clear_yellow();
    int n;
    apply_reset(4'b0001);
    wait_green();
    req = 4'b0010;
    count_run(8'h02, n);
    checks++;
    if (sig !== 8'h01) begin failures++; $display("FAIL clr_setup got sig=%h exp=01", sig); end
    clear = 1'b1;
    req   = 4'b0000;
    @(negedge clk);
    checks++;
    if (sig !== 8'h00) begin failures++; $display("FAIL clr_allred got sig=%h exp=00", sig); end
    clear = 1'b0;
    count_run(8'h00, n);
    checks++;
    if (n !== R_T) begin failures++; $display("FAIL clr_allred_len got=%0d exp=%0d", n, R_T); end
    checks++;
    if (sig !== 8'h02 || phase !== 2'd0 || phase_start !== 1'b1) begin
      failures++;
      $display("FAIL clr_green got sig=%h phase=%0d ps=%b exp 02/0/1", sig, phase, phase_start);
    end
  endtask

  task automatic test_random();
    int c, hold, starts;
    c = 0;
    starts = 0;
    while (c < 1500) begin
      req   = 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 40) == 0);
      hold  = $urandom_range(1, 12);
      repeat (hold) begin
        @(negedge clk);
        c++;
        clear = 1'b0;
        if (phase_start === 1'b1) starts++;
      end
    end
    checks++;
    if (starts < 20) begin
      failures++;
      $display("FAIL rand_activity got=%0d phase starts exp>=20", starts);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    req   = 4'b0000;
    test_reset();
    test_max_green();
    test_min_green();
    test_wraparound();
    test_clear_yellow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
